// File: rtl/cordic_uv_sequencer.sv
// Control sequencer for the 4-lane U/V rotation array.
// Accepts one job (sigma word, lane index, rotation mode), then drives the
// shared shift/sign/sel/ce buses for NUM_ITER micro-rotations, then one
// add/sub step per set bit of SCALE_MASK, then pulses done for one cycle.
// A step is consumed by the array only in a cycle where ce=1. After a stall,
// the step that was not consumed is presented again until it is consumed.
module cordic_uv_sequencer #(
  parameter int WIDTH_SHIFT_BIT = 4,
  parameter int NUM_ITER        = 16,
  parameter logic [(2**WIDTH_SHIFT_BIT)-1:0] SCALE_MASK = 16'h000A,
  parameter int WIDTH_INDEX     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_ITER-1:0]        dir_in,
  input  logic [WIDTH_INDEX-1:0]     index_in,
  input  logic                       rot_mode_in,
  input  logic                       stall,
  output logic                       ce,
  output logic                       sel,
  output logic                       sign_in,
  output logic [WIDTH_SHIFT_BIT-1:0] shift,
  output logic [WIDTH_SHIFT_BIT-1:0] count,
  output logic                       sign_rotation,
  output logic [WIDTH_INDEX-1:0]     index,
  output logic                       busy,
  output logic                       done
);

  localparam int MASK_W = 2**WIDTH_SHIFT_BIT;
  localparam logic [WIDTH_SHIFT_BIT-1:0] LAST_IT = WIDTH_SHIFT_BIT'(NUM_ITER - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state_r;
  logic [NUM_ITER-1:0]        dir_r;
  logic [NUM_ITER-1:0]        dir_next_s;
  logic [WIDTH_SHIFT_BIT:0]   first_scale_s;
  logic [WIDTH_SHIFT_BIT:0]   next_scale_s;

  // Priority encoder: lowest set mask bit strictly above pos (or lowest overall).
  // Result is {found, bit_position}.
  function automatic logic [WIDTH_SHIFT_BIT:0] scale_after(
    input logic [WIDTH_SHIFT_BIT-1:0] pos,
    input logic                       from_start
  );
    logic [WIDTH_SHIFT_BIT:0] r;
    r = {(WIDTH_SHIFT_BIT+1){1'b0}};
    for (int b = MASK_W - 1; b >= 0; b--) begin
      if (SCALE_MASK[b] && (from_start || (b > int'(pos)))) begin
        r = {1'b1, WIDTH_SHIFT_BIT'(b)};
      end
    end
    return r;
  endfunction

  // The sigma word is shifted down so bit 0 is always the next direction.
  assign dir_next_s    = dir_r >> 1'b1;
  assign first_scale_s = scale_after({WIDTH_SHIFT_BIT{1'b0}}, 1'b1);
  assign next_scale_s  = scale_after(shift, 1'b0);

  // Sequencer FSM with registered control buses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      dir_r         <= {NUM_ITER{1'b0}};
      in_ready      <= 1'b1;
      ce            <= 1'b0;
      sel           <= 1'b0;
      sign_in       <= 1'b0;
      shift         <= {WIDTH_SHIFT_BIT{1'b0}};
      count         <= {WIDTH_SHIFT_BIT{1'b0}};
      sign_rotation <= 1'b0;
      index         <= {WIDTH_INDEX{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          ce   <= 1'b0;
          if (in_valid && in_ready) begin
            // Stall is ignored here: step 0 always goes out right after accept.
            state_r       <= ROT;
            dir_r         <= dir_in;
            index         <= index_in;
            sign_rotation <= rot_mode_in;
            sign_in       <= dir_in[0];
            shift         <= {WIDTH_SHIFT_BIT{1'b0}};
            count         <= {WIDTH_SHIFT_BIT{1'b0}};
            sel           <= 1'b0;
            ce            <= 1'b1;
            busy          <= 1'b1;
            in_ready      <= 1'b0;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ROT: begin
          if (!ce) begin
            // Previous step not consumed: keep presenting it.
            ce <= ~stall;
          end else if (count == LAST_IT) begin
            if (first_scale_s[WIDTH_SHIFT_BIT]) begin
              state_r <= SCALE;
              sel     <= 1'b1;
              sign_in <= 1'b1;
              shift   <= first_scale_s[WIDTH_SHIFT_BIT-1:0];
              count   <= {WIDTH_SHIFT_BIT{1'b0}};
              ce      <= ~stall;
            end else begin
              state_r <= DONE;
              sel     <= 1'b0;
              sign_in <= 1'b0;
              shift   <= {WIDTH_SHIFT_BIT{1'b0}};
              count   <= {WIDTH_SHIFT_BIT{1'b0}};
              ce      <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            count   <= count + WIDTH_SHIFT_BIT'(1);
            shift   <= count + WIDTH_SHIFT_BIT'(1);
            dir_r   <= dir_next_s;
            sign_in <= dir_next_s[0];
            ce      <= ~stall;
          end
        end
        SCALE: begin
          if (!ce) begin
            ce <= ~stall;
          end else if (next_scale_s[WIDTH_SHIFT_BIT]) begin
            shift <= next_scale_s[WIDTH_SHIFT_BIT-1:0];
            ce    <= ~stall;
          end else begin
            state_r <= DONE;
            sel     <= 1'b0;
            sign_in <= 1'b0;
            shift   <= {WIDTH_SHIFT_BIT{1'b0}};
            count   <= {WIDTH_SHIFT_BIT{1'b0}};
            ce      <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          done     <= 1'b0;
          ce       <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          done     <= 1'b0;
          ce       <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_uv_sequencer.sv
// Scoreboard bench for cordic_uv_sequencer: stimulus pushes the expected
// per-cycle bus values (tagged with the cycle they must appear in) and a
// monitor per instance pops and compares on every busy cycle.
module tb_cordic_uv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Instance 0: default parameters.
  logic        iv0, ir0, rm0, st0, ce0, sel0, sg0, sr0, bz0, dn0;
  logic [15:0] dir0;
  logic [1:0]  idx0, ix0;
  logic [3:0]  sh0, cn0;

  // Instance 1: NUM_ITER=4, SCALE_MASK=0.
  logic        iv1, ir1, rm1, st1, ce1, sel1, sg1, sr1, bz1, dn1;
  logic [3:0]  dir1;
  logic [1:0]  idx1, ix1;
  logic [3:0]  sh1, cn1;

  cordic_uv_sequencer dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .dir_in(dir0),
    .index_in(idx0), .rot_mode_in(rm0), .stall(st0), .ce(ce0), .sel(sel0),
    .sign_in(sg0), .shift(sh0), .count(cn0), .sign_rotation(sr0),
    .index(ix0), .busy(bz0), .done(dn0)
  );

  cordic_uv_sequencer #(.WIDTH_SHIFT_BIT(4), .NUM_ITER(4),
                        .SCALE_MASK(16'h0000), .WIDTH_INDEX(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .dir_in(dir1),
    .index_in(idx1), .rot_mode_in(rm1), .stall(st1), .ce(ce1), .sel(sel1),
    .sign_in(sg1), .shift(sh1), .count(cn1), .sign_rotation(sr1),
    .index(ix1), .busy(bz1), .done(dn1)
  );

  typedef struct {
    int          cyc;
    logic [14:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] pk(input logic c, input logic s, input logic g,
                                     input logic [3:0] h, input logic [3:0] n,
                                     input logic d, input logic [1:0] x, input logic r);
    return {c, s, g, h, n, d, x, r};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Monitor for instance 0: every busy cycle must match the next expectation.
  always @(negedge clk) begin : mon0
    exp_t        e;
    logic [14:0] a;
    if (bz0 === 1'b1) begin
      a = pk(ce0, sel0, sg0, sh0, cn0, dn0, ix0, sr0);
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL mon0 unexpected busy at cycle %0d: got %h required idle", cyc, a);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || e.v !== a) begin
          fails++;
          $display("FAIL mon0 step: got %h at cycle %0d required %h at cycle %0d",
                   a, cyc, e.v, e.cyc);
        end
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin : mon1
    exp_t        e;
    logic [14:0] a;
    if (bz1 === 1'b1) begin
      a = pk(ce1, sel1, sg1, sh1, cn1, dn1, ix1, sr1);
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL mon1 unexpected busy at cycle %0d: got %h required idle", cyc, a);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || e.v !== a) begin
          fails++;
          $display("FAIL mon1 step: got %h at cycle %0d required %h at cycle %0d",
                   a, cyc, e.v, e.cyc);
        end
      end
    end
  end

  // Expected trace for a default job accepted at posedge a: ROT step k at
  // cycle a+k, scale shifts 1 and 3, then done; nrot limits the ROT steps
  // pushed (for aborted jobs); a stall of slen cycles starting at step sat
  // shows step sat with ce=0 for slen cycles and delays the rest.
  task automatic push0(input int a, input logic [15:0] d, input logic [1:0] x,
                       input logic r, input int sat, input int slen,
                       input int nrot, input bit full);
    int off;
    off = 0;
    for (int k = 0; k < nrot; k++) begin
      if (k == sat) begin
        for (int j = 0; j < slen; j++)
          q0.push_back('{a + k + j, pk(1'b0, 1'b0, d[k], 4'(k), 4'(k), 1'b0, x, r)});
        off = slen;
      end
      q0.push_back('{a + k + off, pk(1'b1, 1'b0, d[k], 4'(k), 4'(k), 1'b0, x, r)});
    end
    if (full) begin
      q0.push_back('{a + 16 + off, pk(1'b1, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0, x, r)});
      q0.push_back('{a + 17 + off, pk(1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, x, r)});
      q0.push_back('{a + 18 + off, pk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, x, r)});
    end
  endtask

  task automatic start0(input logic [15:0] d, input logic [1:0] x, input logic r,
                        output int a);
    iv0 = 1'b1; dir0 = d; idx0 = x; rm0 = r;
    @(posedge clk); #1;
    a = cyc;
    iv0 = 1'b0;
  endtask

  initial begin
    int a;
    rst = 1'b1;
    iv0 = 1'b0; dir0 = 16'h0000; idx0 = 2'd0; rm0 = 1'b0; st0 = 1'b0;
    iv1 = 1'b0; dir1 = 4'h0;     idx1 = 2'd0; rm1 = 1'b0; st1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // {in_ready, ce, done, busy, sel, sign_in, shift, count, sign_rotation, index}
    check("reset0", {15'd0, ir0, ce0, dn0, bz0, sel0, sg0, sh0, cn0, sr0, ix0}, 32'h0001_0000);
    check("reset1", {15'd0, ir1, ce1, dn1, bz1, sel1, sg1, sh1, cn1, sr1, ix1}, 32'h0001_0000);

    // Short job on instance 1: 4 ROT steps, no scale phase, done next.
    iv1 = 1'b1; dir1 = 4'b1001; idx1 = 2'd3; rm1 = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    iv1 = 1'b0;
    q1.push_back('{a + 0, pk(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b1)});
    q1.push_back('{a + 1, pk(1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 2'd3, 1'b1)});
    q1.push_back('{a + 2, pk(1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 2'd3, 1'b1)});
    q1.push_back('{a + 3, pk(1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 2'd3, 1'b1)});
    q1.push_back('{a + 4, pk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'd3, 1'b1)});
    repeat (8) @(posedge clk); #1;
    check("idle1_after_job", {31'd0, ir1}, 32'd1);

    // Default job.
    start0(16'hA5C3, 2'd2, 1'b1, a);
    push0(a, 16'hA5C3, 2'd2, 1'b1, 99, 0, 16, 1'b1);
    repeat (18) @(posedge clk); #1;
    check("default_not_ready_in_done", {31'd0, ir0}, 32'd0);
    @(posedge clk); #1;
    check("default_ready_after_done", {31'd0, ir0}, 32'd1);
    repeat (3) @(posedge clk); #1;

    // Stall of 3 cycles sampled on the edges that would present step 5.
    start0(16'h3C5A, 2'd1, 1'b0, a);
    push0(a, 16'h3C5A, 2'd1, 1'b0, 5, 3, 16, 1'b1);
    repeat (4) @(posedge clk); #1;
    st0 = 1'b1;
    repeat (3) @(posedge clk); #1;
    st0 = 1'b0;
    repeat (20) @(posedge clk); #1;

    // Back-to-back: in_valid stays high; inputs change right after accept.
    start0(16'h1234, 2'd2, 1'b1, a);
    iv0 = 1'b1; dir0 = 16'hFEDC; idx0 = 2'd1; rm0 = 1'b0;
    push0(a, 16'h1234, 2'd2, 1'b1, 99, 0, 16, 1'b1);
    push0(a + 20, 16'hFEDC, 2'd1, 1'b0, 99, 0, 16, 1'b1);
    repeat (20) @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (22) @(posedge clk); #1;

    // Reset while count=7: aborts without done.
    start0(16'h0F0F, 2'd3, 1'b1, a);
    push0(a, 16'h0F0F, 2'd3, 1'b1, 99, 0, 8, 1'b0);
    repeat (7) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midjob_reset_state", {15'd0, ir0, ce0, dn0, bz0, sel0, sg0, sh0, cn0, sr0, ix0}, 32'h0001_0000);
    repeat (4) @(posedge clk); #1;
    check("midjob_no_done", {30'd0, dn0, bz0}, 32'd0);

    // Fresh job after the abort starts again from step 0.
    start0(16'h8001, 2'd0, 1'b1, a);
    push0(a, 16'h8001, 2'd0, 1'b1, 99, 0, 16, 1'b1);
    repeat (22) @(posedge clk); #1;

    check("queue0_drained", q0.size(), 32'd0);
    check("queue1_drained", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_uv_sequencer.md
Name: cordic_uv_sequencer

Overview:
- Control stage directly upstream of the 4-lane U/V rotation array (four process lanes sharing shift/sign/sel/ce).
- Accepts one rotation job per handshake: a direction word of NUM_ITER sigma bits from the vectoring stage, a lane index and a rotation mode.
- Drives the shared per-cycle control buses for NUM_ITER micro-rotations, then a gain-compensation add/sub phase, then pulses done.

Parameters:
- WIDTH_SHIFT_BIT, 4, width of shift/count buses.
- NUM_ITER, 16, micro-rotations per job; legal range 1..2^WIDTH_SHIFT_BIT.
- SCALE_MASK, 16'h000A, bit k set means one scale step with shift k (sign_in=1, subtract); width 2^WIDTH_SHIFT_BIT.
- WIDTH_INDEX, 2, lane index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  sequencer can accept a job.
- dir_in  in  NUM_ITER  sigma bits; bit i is the direction of iteration i (1 = negative).
- index_in  in  WIDTH_INDEX  lane index for the job.
- rot_mode_in  in  1  rotation mode, forwarded as sign_rotation.
- stall  in  1  freeze the sequence this cycle.
- ce  out  1  array enable.
- sel  out  1  0 = rotation path, 1 = add/sub scale path.
- sign_in  out  1  direction for the current step.
- shift  out  WIDTH_SHIFT_BIT  shift amount for the current step.
- count  out  WIDTH_SHIFT_BIT  rotation iteration number; 0 outside ROT.
- sign_rotation  out  1  latched rot_mode_in.
- index  out  WIDTH_INDEX  latched index_in.
- busy  out  1  job in progress (ROT, SCALE or DONE).
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; in_ready=1; ce, sel, sign_in, shift, count, sign_rotation, index, busy, done all 0. Reset mid-job aborts it without a done pulse.
- All outputs are registered.
- IDLE: in_ready=1 and ce=0.
  - Job accepted when in_valid and in_ready are both 1 at an edge.
  - On accept: latch dir_in, index_in and rot_mode_in; go to ROT with it=0.
  - in_valid while busy is ignored; no queueing.
- ROT: ce=1, sel=0, shift=it, count=it, sign_in=dir[it].
  - it increments each non-stalled cycle.
  - After it=NUM_ITER-1: go to SCALE if SCALE_MASK≠0, else go to DONE.
- SCALE:
  - Visits the set bits of SCALE_MASK in ascending order, one per non-stalled cycle.
  - Outputs: ce=1, sel=1, sign_in=1, shift=bit position, count=0.
  - The next set bit comes from a priority encoder on the mask above the current position.
  - After the highest set bit: go to DONE.
- DONE: ce=0, done=1 for exactly one cycle; next cycle IDLE with in_ready=1.
- stall=1 in ROT or SCALE:
  - ce=0; shift, count, sign_in and sel hold their values; the step counter does not advance.
  - The held step is re-presented with ce=1 once stall drops.
- stall is ignored in IDLE and DONE.
- Latency from accept edge E:
  - first ROT step visible in cycle E+1;
  - total busy cycles = NUM_ITER + popcount(SCALE_MASK) + 1 + stalled cycles.
  - Defaults: steps occupy cycles E+1..E+18, done at E+19, in_ready=1 at E+20.
- index and sign_rotation stay stable from accept until the next accept; reset clears them.
- NUM_ITER=2^WIDTH_SHIFT_BIT: the iteration counter must not wrap early and must reach all codes 0..2^WIDTH_SHIFT_BIT-1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> in_ready=1, ce=0, done=0, all buses 0.
- Default job: dir_in=16'hA5C3, index_in=2, rot_mode_in=1, accept at E.
  - E+1..E+16: shift=count=0..15, sign_in equals dir bit i, sel=0, ce=1.
  - E+17: shift=1, sel=1, sign_in=1. E+18: shift=3, sel=1, sign_in=1.
  - E+19: done=1. Throughout: index=2, sign_rotation=1.
- Stall: assert stall at the cycle where shift=5, for 3 cycles -> ce=0 with shift held at 5; resume shows shift=5 with ce=1; done at E+22.
- Back-to-back: keep in_valid high during a job -> second job accepted only at E+20; the second dir word is the one present at E+20.
- Reset mid-job: rst=1 when count=7 -> next cycle IDLE, all outputs 0, no done pulse; a new job then runs from shift=0.
- SCALE_MASK=0, NUM_ITER=4: accept at E -> ROT in cycles E+1..E+4, done at E+5, no sel=1 cycle.
